// File: rtl/rotation_arbiter_if.sv
// Bundle between graphics requesters, the shared CORDIC rotator and the rotation arbiter.
// The slave modport is the arbiter's view; the master modport drives requesters and rotator results.
interface rotation_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [12*NREQ-1:0]   req_x;
    logic [12*NREQ-1:0]   req_y;
    logic [32*NREQ-1:0]   req_angle;
    logic [11:0]          rot_x;
    logic [11:0]          rot_y;
    logic [31:0]          rot_angle;
    logic [11:0]          rot_xr;
    logic [10:0]          rot_yr;
    logic [NREQ-1:0]      res_valid;
    logic [NREQ-1:0]      res_ready;
    logic [12*NREQ-1:0]   res_x;
    logic [11*NREQ-1:0]   res_y;
    logic                 busy;

    modport slave (
        input  req_valid, req_x, req_y, req_angle, rot_xr, rot_yr, res_ready,
        output req_ready, rot_x, rot_y, rot_angle, res_valid, res_x, res_y, busy
    );

    modport master (
        output req_valid, req_x, req_y, req_angle, rot_xr, rot_yr, res_ready,
        input  req_ready, rot_x, rot_y, rot_angle, res_valid, res_x, res_y, busy
    );
endinterface

// File: rtl/rotation_arbiter.sv
// Round-robin sharing of one pipelined CORDIC rotator; folds angles into +/-90 deg and
// routes tagged results back through credit-protected per-requester FIFOs.
module rotation_arbiter #(
    parameter int NREQ       = 2,
    parameter int LATENCY    = 13,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    rotation_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_credit [NREQ];
    logic [11:0]      r_rotX;
    logic [11:0]      r_rotY;
    logic [31:0]      r_rotAngle;
    logic [LATENCY-1:0] r_tagValid;
    logic [IDW-1:0]   r_tagId [LATENCY];
    logic [AW-1:0]    r_wrPtr [NREQ];
    logic [AW-1:0]    r_rdPtr [NREQ];
    logic [CW-1:0]    r_count [NREQ];
    logic [11:0]      r_memX [NREQ][FIFO_DEPTH];
    logic [10:0]      r_memY [NREQ][FIFO_DEPTH];

    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_push;
    logic [NREQ-1:0]  w_pop;
    logic [NREQ-1:0]  w_nonEmpty;
    logic             w_anyGrant;
    logic [IDW-1:0]   w_grantId;
    logic [IDW-1:0]   w_ptrNext;
    logic [11:0]      w_selX;
    logic [11:0]      w_selY;
    logic [31:0]      w_selAngle;
    logic [11:0]      w_foldX;
    logic [11:0]      w_foldY;
    logic [31:0]      w_foldAngle;

    function automatic logic [11:0] negSat(input logic [11:0] v);
        return (v == 12'h800) ? 12'h7FF : (~v + 12'd1);
    endfunction

    function automatic logic [AW-1:0] bumpPtr(input logic [AW-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // A requester may only be granted while it still owns a reserved FIFO slot.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_eligible[i] = bus.req_valid[i] && (r_credit[i] != '0);
            w_push[i]     = r_tagValid[LATENCY-1] && (r_tagId[LATENCY-1] == IDW'(i));
            w_nonEmpty[i] = (r_count[i] != '0);
            w_pop[i]      = w_nonEmpty[i] && bus.res_ready[i];
        end
    end

    always_comb begin
        int             idx;
        logic [IDW-1:0] idxSel;
        idx        = 0;
        idxSel     = '0;
        w_grant    = '0;
        w_anyGrant = 1'b0;
        w_grantId  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idxSel = IDW'(idx);
            if (!w_anyGrant && !reset && w_eligible[idxSel]) begin
                w_anyGrant      = 1'b1;
                w_grantId       = idxSel;
                w_grant[idxSel] = 1'b1;
            end
        end
        w_ptrNext = (int'(w_grantId) == NREQ - 1) ? '0 : w_grantId + 1'b1;
    end

    // Quadrants II/III are rotated by 180 deg with the vector negated, which leaves the result unchanged.
    always_comb begin
        w_selX     = bus.req_x[12*w_grantId +: 12];
        w_selY     = bus.req_y[12*w_grantId +: 12];
        w_selAngle = bus.req_angle[32*w_grantId +: 32];
        w_foldX    = w_selX;
        w_foldY    = w_selY;
        w_foldAngle = w_selAngle;
        if (w_selAngle[31] ^ w_selAngle[30]) begin
            w_foldX     = negSat(w_selX);
            w_foldY     = negSat(w_selY);
            w_foldAngle = w_selAngle + 32'h8000_0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_rotX     <= '0;
            r_rotY     <= '0;
            r_rotAngle <= '0;
        end else if (w_anyGrant) begin
            r_ptr      <= w_ptrNext;
            r_rotX     <= w_foldX;
            r_rotY     <= w_foldY;
            r_rotAngle <= w_foldAngle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tagValid <= '0;
            for (int k = 0; k < LATENCY; k++) r_tagId[k] <= '0;
        end else begin
            r_tagValid <= {r_tagValid[LATENCY-2:0], w_anyGrant};
            r_tagId[0] <= w_grantId;
            for (int k = 1; k < LATENCY; k++) r_tagId[k] <= r_tagId[k-1];
        end
    end

    // Credits count free slots minus results still in the rotator, so a push never finds a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_credit[i] <= CW'(FIFO_DEPTH);
                r_count[i]  <= '0;
                r_wrPtr[i]  <= '0;
                r_rdPtr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && !w_pop[i])      r_credit[i] <= r_credit[i] - 1'b1;
                else if (!w_grant[i] && w_pop[i]) r_credit[i] <= r_credit[i] + 1'b1;
                if (w_push[i] && !w_pop[i])       r_count[i] <= r_count[i] + 1'b1;
                else if (!w_push[i] && w_pop[i])  r_count[i] <= r_count[i] - 1'b1;
                if (w_push[i]) r_wrPtr[i] <= bumpPtr(r_wrPtr[i]);
                if (w_pop[i])  r_rdPtr[i] <= bumpPtr(r_rdPtr[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_push[i]) begin
                r_memX[i][r_wrPtr[i]] <= bus.rot_xr;
                r_memY[i][r_wrPtr[i]] <= bus.rot_yr;
            end
        end
    end

    always_comb begin
        bus.req_ready = w_grant;
        bus.rot_x     = r_rotX;
        bus.rot_y     = r_rotY;
        bus.rot_angle = r_rotAngle;
        bus.res_valid = w_nonEmpty;
        bus.res_x     = '0;
        bus.res_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.res_x[12*i +: 12] = r_memX[i][r_rdPtr[i]];
            bus.res_y[11*i +: 11] = r_memY[i][r_rdPtr[i]];
        end
        bus.busy = (|r_tagValid) || (|w_nonEmpty);
    end
endmodule
